// File: rtl/udp_audio_pkg.sv
// Shared types and constants for the UDP audio transmit scheduler.
package udp_audio_pkg;

    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_FILL,
        BUF_PEND
    } buf_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND_AUD,
        ARB_SEND_CTRL
    } arb_state_t;

    localparam logic [15:0] CTRL_LEN   = 16'd4;
    localparam logic [2:0]  STARVE_MAX = 3'd4;

endpackage

// File: rtl/pingpong_pack_buf.sv
// Two ping-pong payload buffers packing 16-bit samples left-aligned, with
// per-buffer FREE/FILL/PEND state, byte length and dropped-sample accounting.
module pingpong_pack_buf
    import udp_audio_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_PKT = 60,
    parameter int unsigned PAYLOAD_W       = 960
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          wav_in_data,
    input  logic                 wav_wren,
    input  logic                 flush,
    input  logic                 rel_en,
    input  logic                 rel_sel,
    output logic [PAYLOAD_W-1:0] buf0_data,
    output logic [PAYLOAD_W-1:0] buf1_data,
    output logic [15:0]          buf0_len,
    output logic [15:0]          buf1_len,
    output logic                 buf0_pend,
    output logic                 buf1_pend,
    output logic                 closing,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);
    localparam int unsigned      IDX_W    = $clog2(SAMPLES_PER_PKT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_PKT);

    buf_state_t           buf_st   [2];
    logic [PAYLOAD_W-1:0] buf_data [2];
    logic [15:0]          buf_len  [2];
    logic [IDX_W-1:0]     fill_idx;
    logic [IDX_W-1:0]     idx_inc;
    logic [IDX_W-1:0]     close_cnt;
    logic                 has_fill;
    logic                 fsel;
    logic                 other_free;

    always_comb begin
        has_fill   = (buf_st[0] == BUF_FILL) || (buf_st[1] == BUF_FILL);
        fsel       = (buf_st[1] == BUF_FILL);
        idx_inc    = fill_idx + IDX_W'(1);
        closing    = has_fill && ((wav_wren && (idx_inc == LAST_IDX)) ||
                                  (flush && (wav_wren || (fill_idx != '0))));
        close_cnt  = wav_wren ? idx_inc : fill_idx;
        // A buffer being handed back on this same edge counts as free.
        other_free = (buf_st[~fsel] == BUF_FREE) || (rel_en && (rel_sel == ~fsel));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_st[0]   <= BUF_FILL;
            buf_st[1]   <= BUF_FREE;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_len[0]  <= '0;
            buf_len[1]  <= '0;
            fill_idx    <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            overflow <= 1'b0;
            if (rel_en) begin
                buf_st[rel_sel] <= has_fill ? BUF_FREE : BUF_FILL;
                if (!has_fill) buf_data[rel_sel] <= '0;
            end
            if (has_fill) begin
                for (int unsigned k = 0; k < SAMPLES_PER_PKT; k++) begin
                    if (wav_wren && (IDX_W'(k) == fill_idx))
                        buf_data[fsel][PAYLOAD_W-1-16*k -: 16] <= wav_in_data;
                end
                if (closing) begin
                    buf_st[fsel]  <= BUF_PEND;
                    buf_len[fsel] <= 16'({close_cnt, 1'b0});
                    fill_idx      <= '0;
                    if (other_free) begin
                        buf_st[~fsel]   <= BUF_FILL;
                        buf_data[~fsel] <= '0;
                    end
                end else if (wav_wren) begin
                    fill_idx <= idx_inc;
                end
            end else if (wav_wren) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign buf0_data = buf_data[0];
    assign buf1_data = buf_data[1];
    assign buf0_len  = buf_len[0];
    assign buf1_len  = buf_len[1];
    assign buf0_pend = (buf_st[0] == BUF_PEND);
    assign buf1_pend = (buf_st[1] == BUF_PEND);

endmodule

// File: rtl/udp_audio_tx_sched.sv
// Arbitrates the UDP send port between packed audio buffers and a 4-byte
// control message, with audio priority and a control anti-starvation counter.
module udp_audio_tx_sched
    import udp_audio_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_PKT = 60,
    parameter int unsigned PAYLOAD_W       = 960
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          wav_in_data,
    input  logic                 wav_wren,
    input  logic                 flush,
    input  logic                 ctrl_req,
    input  logic [31:0]          ctrl_data,
    output logic                 ctrl_ack,
    output logic                 udp_send_data_valid,
    input  logic                 udp_send_data_ready,
    output logic [PAYLOAD_W-1:0] udp_send_data,
    output logic [15:0]          udp_send_data_length,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);
    logic [PAYLOAD_W-1:0] buf0_data, buf1_data;
    logic [15:0]          buf0_len, buf1_len;
    logic                 buf0_pend, buf1_pend, closing;
    logic                 rel_en, pend_any, pick_sel, grant_ctrl;
    logic                 aud_ptr, cur_sel;
    logic [2:0]           starve_cnt;
    arb_state_t           state;

    pingpong_pack_buf #(
        .SAMPLES_PER_PKT(SAMPLES_PER_PKT),
        .PAYLOAD_W      (PAYLOAD_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wav_in_data(wav_in_data),
        .wav_wren   (wav_wren),
        .flush      (flush),
        .rel_en     (rel_en),
        .rel_sel    (cur_sel),
        .buf0_data  (buf0_data),
        .buf1_data  (buf1_data),
        .buf0_len   (buf0_len),
        .buf1_len   (buf1_len),
        .buf0_pend  (buf0_pend),
        .buf1_pend  (buf1_pend),
        .closing    (closing),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    // A buffer closing on this edge holds off control for one cycle so
    // that the audio packet wins, as it would had it been PEND already.
    always_comb begin
        pend_any   = buf0_pend || buf1_pend;
        pick_sel   = (aud_ptr ? buf1_pend : buf0_pend) ? aud_ptr : ~aud_ptr;
        grant_ctrl = ctrl_req && ((starve_cnt >= STARVE_MAX) || (!pend_any && !closing));
        rel_en     = (state == ARB_SEND_AUD) && udp_send_data_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ARB_IDLE;
            udp_send_data_valid  <= 1'b0;
            udp_send_data        <= '0;
            udp_send_data_length <= '0;
            ctrl_ack             <= 1'b0;
            aud_ptr              <= 1'b0;
            cur_sel              <= 1'b0;
            starve_cnt           <= '0;
        end else begin
            ctrl_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_ctrl) begin
                        state                <= ARB_SEND_CTRL;
                        udp_send_data_valid  <= 1'b1;
                        udp_send_data        <= {ctrl_data, {(PAYLOAD_W-32){1'b0}}};
                        udp_send_data_length <= CTRL_LEN;
                        starve_cnt           <= '0;
                    end else if (pend_any) begin
                        state                <= ARB_SEND_AUD;
                        udp_send_data_valid  <= 1'b1;
                        cur_sel              <= pick_sel;
                        udp_send_data        <= pick_sel ? buf1_data : buf0_data;
                        udp_send_data_length <= pick_sel ? buf1_len : buf0_len;
                        starve_cnt           <= ctrl_req ? starve_cnt + 3'd1 : 3'd0;
                    end
                end
                ARB_SEND_AUD: begin
                    if (udp_send_data_ready) begin
                        state               <= ARB_IDLE;
                        udp_send_data_valid <= 1'b0;
                        aud_ptr             <= ~cur_sel;
                    end
                end
                ARB_SEND_CTRL: begin
                    if (udp_send_data_ready) begin
                        state               <= ARB_IDLE;
                        udp_send_data_valid <= 1'b0;
                        ctrl_ack            <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_audio_tx_sched.sv
// Directed bench for udp_audio_tx_sched with hand-computed expectations.
module tb_udp_audio_tx_sched;
    import udp_audio_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  wav_in_data = '0;
    logic         wav_wren = 1'b0;
    logic         flush = 1'b0;
    logic         ctrl_req = 1'b0;
    logic [31:0]  ctrl_data = '0;
    logic         ctrl_ack;
    logic         udp_send_data_valid;
    logic         udp_send_data_ready = 1'b0;
    logic [959:0] udp_send_data;
    logic [15:0]  udp_send_data_length;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int total = 0;
    int bad = 0;
    int n_log = 0;
    int n_ack = 0;
    int n_ovf = 0;
    logic [31:0]  log_top [16];
    logic [15:0]  log_len [16];
    logic         log_rz  [16];
    logic [959:0] snap;

    udp_audio_tx_sched #(
        .SAMPLES_PER_PKT(60),
        .PAYLOAD_W      (960)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wav_in_data         (wav_in_data),
        .wav_wren            (wav_wren),
        .flush               (flush),
        .ctrl_req            (ctrl_req),
        .ctrl_data           (ctrl_data),
        .ctrl_ack            (ctrl_ack),
        .udp_send_data_valid (udp_send_data_valid),
        .udp_send_data_ready (udp_send_data_ready),
        .udp_send_data       (udp_send_data),
        .udp_send_data_length(udp_send_data_length),
        .overflow            (overflow),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && udp_send_data_valid && udp_send_data_ready) begin
            if (n_log < 16) begin
                log_top[n_log] = udp_send_data[959:928];
                log_len[n_log] = udp_send_data_length;
                log_rz[n_log]  = ~|udp_send_data[927:0];
            end
            n_log++;
        end
    end

    always @(negedge clk) begin
        if (ctrl_ack) n_ack++;
        if (overflow) n_ovf++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wav_wren = 1'b0;
        flush = 1'b0;
        ctrl_req = 1'b0;
        udp_send_data_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_log = 0;
        n_ack = 0;
        n_ovf = 0;
    endtask

    task automatic push(input logic [15:0] v);
        wav_in_data = v;
        wav_wren = 1'b1;
        @(negedge clk);
        wav_wren = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int i = 0;
        while (!udp_send_data_valid && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check_eq(tag, 64'(udp_send_data_valid), 64'd1);
    endtask

    initial begin
        int errs;

        // reset values
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("rst_data", 64'(|udp_send_data), 64'd0);
        check_eq("rst_len", 64'(udp_send_data_length), 64'd0);
        check_eq("rst_ack", 64'(ctrl_ack), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_drop", 64'(drop_cnt), 64'd0);

        // full packet, sink always ready
        do_reset();
        udp_send_data_ready = 1'b1;
        for (int i = 1; i <= 60; i++) push(16'(i));
        check_eq("t1_valid_n", 64'(udp_send_data_valid), 64'd0);
        @(negedge clk);
        check_eq("t1_valid_n1", 64'(udp_send_data_valid), 64'd1);
        check_eq("t1_len", 64'(udp_send_data_length), 64'd120);
        check_eq("t1_first", 64'(udp_send_data[959:944]), 64'h0001);
        check_eq("t1_last", 64'(udp_send_data[15:0]), 64'h003C);
        @(negedge clk);
        check_eq("t1_valid_drop", 64'(udp_send_data_valid), 64'd0);
        check_eq("t1_nxfer", 64'(n_log), 64'd1);
        check_eq("t1_b0_free", 64'(dut.u_buf.buf_st[0]), 64'(BUF_FREE));

        // backpressure for 500 cycles
        do_reset();
        for (int i = 1; i <= 60; i++) push(16'(i));
        @(negedge clk);
        snap = udp_send_data;
        errs = 0;
        repeat (500) begin
            @(negedge clk);
            if (!udp_send_data_valid || udp_send_data !== snap || udp_send_data_length !== 16'd120)
                errs++;
        end
        check_eq("t2_hold", 64'(errs), 64'd0);
        check_eq("t2_first", 64'(snap[959:944]), 64'h0001);
        check_eq("t2_noxfer", 64'(n_log), 64'd0);
        udp_send_data_ready = 1'b1;
        @(negedge clk);
        udp_send_data_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t2_nxfer", 64'(n_log), 64'd1);
        check_eq("t2_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t2_b0_free", 64'(dut.u_buf.buf_st[0]), 64'(BUF_FREE));

        // partial buffer flush, then an empty flush
        do_reset();
        for (int i = 0; i < 7; i++) push(16'h0011 + 16'(i));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t3_valid", 5);
        check_eq("t3_len", 64'(udp_send_data_length), 64'd14);
        check_eq("t3_s0", 64'(udp_send_data[959:944]), 64'h0011);
        check_eq("t3_s6", 64'(udp_send_data[863:848]), 64'h0017);
        check_eq("t3_tail_zero", 64'(|udp_send_data[847:0]), 64'd0);
        udp_send_data_ready = 1'b1;
        @(negedge clk);
        udp_send_data_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_nxfer", 64'(n_log), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t3_empty_flush_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t3_empty_flush_nxfer", 64'(n_log), 64'd1);

        // both buffers full, three samples dropped
        do_reset();
        for (int i = 1; i <= 123; i++) push(16'(i));
        @(negedge clk);
        check_eq("t4_ovf_pulses", 64'(n_ovf), 64'd3);
        check_eq("t4_drop_cnt", 64'(drop_cnt), 64'd3);
        udp_send_data_ready = 1'b1;
        repeat (6) @(negedge clk);
        udp_send_data_ready = 1'b0;
        check_eq("t4_nxfer", 64'(n_log), 64'd2);
        check_eq("t4_p0_first", 64'(log_top[0][31:16]), 64'd1);
        check_eq("t4_p0_len", 64'(log_len[0]), 64'd120);
        check_eq("t4_p1_first", 64'(log_top[1][31:16]), 64'd61);
        check_eq("t4_p1_len", 64'(log_len[1]), 64'd120);
        check_eq("t4_b0_fill", 64'(dut.u_buf.buf_st[0]), 64'(BUF_FILL));

        // control request arriving with a closing buffer
        do_reset();
        udp_send_data_ready = 1'b1;
        for (int i = 1; i <= 59; i++) push(16'(i));
        ctrl_req = 1'b1;
        ctrl_data = 32'hDEADBEEF;
        push(16'd60);
        repeat (20) begin
            if (ctrl_ack) ctrl_req = 1'b0;
            if (udp_send_data_valid && udp_send_data_length == 16'd4) ctrl_data = 32'h0BADF00D;
            @(negedge clk);
        end
        check_eq("t5_nxfer", 64'(n_log), 64'd2);
        check_eq("t5_aud_len", 64'(log_len[0]), 64'd120);
        check_eq("t5_aud_first", 64'(log_top[0][31:16]), 64'd1);
        check_eq("t5_ctrl_len", 64'(log_len[1]), 64'd4);
        check_eq("t5_ctrl_data", 64'(log_top[1]), 64'hDEADBEEF);
        check_eq("t5_ctrl_rest", 64'(log_rz[1]), 64'd1);
        check_eq("t5_ack_cnt", 64'(n_ack), 64'd1);
        ctrl_req = 1'b1;
        ctrl_data = 32'hCAFE0001;
        @(negedge clk);
        check_eq("t5_idle_ctrl_valid", 64'(udp_send_data_valid), 64'd1);
        check_eq("t5_idle_ctrl_word", 64'(udp_send_data[959:928]), 64'hCAFE0001);
        @(negedge clk);
        check_eq("t5_ack_timing", 64'(ctrl_ack), 64'd1);
        ctrl_req = 1'b0;

        // anti-starvation under continuous audio, then reset during a send
        do_reset();
        for (int c = 0; c < 480; c++) begin
            if (ctrl_ack) ctrl_req = 1'b0;
            wav_in_data = 16'(c + 1);
            wav_wren = 1'b1;
            if (c == 59) begin
                ctrl_req = 1'b1;
                ctrl_data = 32'hA5A50004;
            end
            udp_send_data_ready = (c == 150 || c == 230 || c == 310 || c == 390 || c == 470);
            @(negedge clk);
        end
        wav_wren = 1'b0;
        udp_send_data_ready = 1'b0;
        check_eq("t6_nxfer", 64'(n_log), 64'd5);
        for (int i = 0; i < 4; i++) check_eq($sformatf("t6_aud%0d_len", i), 64'(log_len[i]), 64'd120);
        check_eq("t6_aud0_first", 64'(log_top[0][31:16]), 64'd60 - 64'd59);
        check_eq("t6_aud1_first", 64'(log_top[1][31:16]), 64'd61);
        check_eq("t6_ctrl_len", 64'(log_len[4]), 64'd4);
        check_eq("t6_ctrl_data", 64'(log_top[4]), 64'hA5A50004);
        check_eq("t6_ack_cnt", 64'(n_ack), 64'd1);
        check_eq("t6_pre_rst_valid", 64'(udp_send_data_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t6_rst_data", 64'(|udp_send_data), 64'd0);
        check_eq("t6_rst_len", 64'(udp_send_data_length), 64'd0);
        check_eq("t6_rst_drop", 64'(drop_cnt), 64'd0);
        check_eq("t6_rst_ack", 64'(ctrl_ack), 64'd0);
        check_eq("t6_rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        n_log = 0;
        udp_send_data_ready = 1'b1;
        for (int i = 0; i < 60; i++) push(16'h0100 + 16'(i));
        repeat (4) @(negedge clk);
        check_eq("t6_post_nxfer", 64'(n_log), 64'd1);
        check_eq("t6_post_first", 64'(log_top[0][31:16]), 64'h0100);
        check_eq("t6_post_len", 64'(log_len[0]), 64'd120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_audio_tx_sched.md
# udp_audio_tx_sched

Sequences the UDP transmit port of the Ethernet path. It packs 16-bit audio samples from the `wav_in_data`/`wav_wren` stream into ping-pong payload buffers, and arbitrates the single `udp_send_data` valid/ready interface between full audio packets and a low-rate 4-byte control/status message. It sits between the audio processing chain and `ethernet_test`, in place of direct sample forwarding.

## Interface
- `SAMPLES_PER_PKT`, 60: samples per full audio packet (1..60).
- `PAYLOAD_W`, 960: payload bus width. Must be at least 16*`SAMPLES_PER_PKT`.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `wav_in_data` input 16: audio sample.
- `wav_wren` input 1: one-cycle sample strobe.
- `flush` input 1: pulse; closes a partially filled buffer.
- `ctrl_req` input 1: level; a control packet is pending.
- `ctrl_data` input 32: control word, sampled at grant.
- `ctrl_ack` output 1: one-cycle pulse when the control packet is accepted by the sink.
- `udp_send_data_valid` output 1: packet offered.
- `udp_send_data_ready` input 1: sink accepts the packet.
- `udp_send_data` output `PAYLOAD_W`: payload, left-aligned; first byte sent = bits [PAYLOAD_W-1 -: 8].
- `udp_send_data_length` output 16: payload length in bytes.
- `overflow` output 1: one-cycle pulse per dropped sample.
- `drop_cnt` output 16: dropped-sample count, saturating at 16'hFFFF.

## Operation
- Two buffers, B0 and B1. Each buffer is in one of three states: FREE, FILL, or PEND. Each PEND buffer also holds a byte length.
- Exactly one buffer may be in FILL. After reset B0 is FILL and B1 is FREE.
- Sample k of a buffer is written to bits [PAYLOAD_W-1-16k -: 16] and the fill index increments. Unwritten bits read 0.
- On the `SAMPLES_PER_PKT`-th sample, the buffer goes to PEND with length 2*`SAMPLES_PER_PKT`. The other buffer becomes FILL if it is FREE; otherwise no buffer is in FILL.
- `flush` with fill index > 0 closes the FILL buffer as PEND with length 2*index. `flush` with index 0 is ignored.
- `wav_wren` together with `flush`: the sample is written first, then the buffer closes.
- `wav_wren` while no buffer is in FILL: the sample is dropped, `overflow` pulses and `drop_cnt` increments.
- A buffer returns to FREE on its handshake. If no buffer is in FILL, the freed buffer becomes FILL in the same edge.
- Arbiter FSM states:
  - IDLE: if any buffer is PEND, go to SEND_AUD with the oldest PEND buffer. Else if `ctrl_req`, go to SEND_CTRL.
  - SEND_AUD and SEND_CTRL: wait for `udp_send_data_ready`, then return to IDLE.
- Audio has strict priority over control.
- Anti-starvation: after 4 consecutive audio grants while `ctrl_req` is high, the next grant goes to control.
- In SEND_CTRL the payload is `ctrl_data` in [PAYLOAD_W-1 -: 32], the remaining bits are 0, and length is 4.

## Timing
- Reset values: `udp_send_data_valid`=0, `udp_send_data`=0, `udp_send_data_length`=0, `ctrl_ack`=0, `overflow`=0, `drop_cnt`=0. FSM=IDLE; fill index=0; oldest-PEND pointer=B0; starvation counter=0.
- All outputs are registered.
- Valid timing:
  - Closing edge at cycle N, FSM in IDLE: valid=1 at N+1, length correct at N+1.
  - `ctrl_req` high in IDLE, no PEND buffer: valid=1 the next cycle.
- Handshake: transfer on the edge where valid && ready.
  - While valid=1 and ready=0, data and length are held stable.
  - Valid drops the cycle after the transfer; the next grant is one IDLE cycle later. Minimum spacing between packets is 2 cycles.
  - `ctrl_ack` pulses the cycle after the control transfer.
- Ready high while valid=0 has no effect.
- `ctrl_data` is captured on the IDLE→SEND_CTRL edge. Later changes do not affect the offered packet.
- Reset mid-transfer: outputs clear immediately. The partial buffer and any PEND data are discarded.

## Structure
- Package `udp_audio_pkg` holds:
  - buffer-state enum (FREE/FILL/PEND)
  - arbiter-state enum (IDLE/SEND_AUD/SEND_CTRL)
  - `CTRL_LEN`=16'd4
  - `STARVE_MAX`=4
- One sub-module, `pingpong_pack_buf`: the two buffers, the fill index and the per-buffer state/length. The arbiter FSM lives in the top.

## Test plan
- 60 samples 16'h0001..16'h003C, ready=1: one packet, length 120, bits [959:944]=16'h0001, bits [15:0]=16'h003C.
- Same 60 samples with ready held low for 500 cycles: valid stays 1 and data stays stable throughout; exactly one transfer when ready rises; B0 returns to FREE.
- 7 samples then `flush`: length 14, bits [847:0]=0. A second `flush` with no new samples produces no packet.
- Ready=0 while 120 samples arrive, then 3 more samples: `overflow` pulses 3 times, `drop_cnt`=3. Releasing ready yields two 120-byte packets, B0 first.
- `ctrl_req` with `ctrl_data`=32'hDEADBEEF in the same cycle a buffer closes: the audio packet goes first, then control with length 4 and [959:928]=32'hDEADBEEF; `ctrl_ack` pulses once.
- Continuous full audio buffers with `ctrl_req` high: control is granted after the 4th audio packet. `rst_n` pulled low during a send: all outputs are 0 the next cycle and the first packet after reset starts at sample 0.
